// File: rtl/alu_16b.sv
// ---------------------------------------------------------------------------
// alu_16b -- 16-bit execute-stage ALU with registered result and flags.
//
// Purpose:
//   Computes one of the opcode functions of A and B combinationally, then
//   captures the result and its zero / negative / signed-overflow flags in
//   output registers. Latency is one clock.
//
// Configuration macro:
//   ALU16_SHIFT_OPS_EN -- when defined, ops 8/9/10 are SLL/SRL/SRA by B[3:0].
//                         When undefined, those ops behave as reserved
//                         (R = 0) and no shifter is built.
//
// Ports:
//   clk        in   1      system clock, rising-edge
//   reset      in   1      synchronous active-high; R=0, isZero=1, others 0
//   en         in   1      capture enable; outputs hold while low
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   op         in   4      operation select
//   R          out  WIDTH  registered result
//   isZero     out  1      registered, R == 0
//   isNegative out  1      registered, R[WIDTH-1]
//   ovfl       out  1      registered signed overflow (ADD/SUB only)
// ---------------------------------------------------------------------------
module alu_16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] R,
  output logic             isZero,
  output logic             isNegative,
  output logic             ovfl
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_NAND  = 4'd6;
  localparam logic [3:0] OP_INV   = 4'd7;
`ifdef ALU16_SHIFT_OPS_EN
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
`endif
  localparam logic [3:0] OP_SLT   = 4'd11;
  localparam logic [3:0] OP_PASSB = 4'd12;

  logic [WIDTH-1:0] sumVal;
  logic [WIDTH-1:0] diffVal;
  logic             lessThan;
  logic [WIDTH-1:0] resultNext;
  logic             ovflNext;

  assign sumVal  = A + B;
  assign diffVal = A - B;

  // Signed A < B. When the signs differ the answer is simply A's sign and the
  // subtraction may overflow; when they match the difference cannot overflow,
  // so its sign bit is the true sign of A-B.
  assign lessThan = (A[WIDTH-1] != B[WIDTH-1]) ? A[WIDTH-1] : diffVal[WIDTH-1];

`ifdef ALU16_SHIFT_OPS_EN
  logic [3:0]       shiftAmt;
  logic [WIDTH-1:0] sllVal;
  logic [WIDTH-1:0] srlVal;
  logic [WIDTH-1:0] sraVal;

  // Only the low four bits of B select the shift distance.
  assign shiftAmt = B[3:0];
  assign sllVal   = A << shiftAmt;
  assign srlVal   = A >> shiftAmt;
  assign sraVal   = $signed(A) >>> shiftAmt;
`endif

  always_comb begin
    resultNext = '0;
    ovflNext   = 1'b0;
    case (op)
      OP_AND:   resultNext = A & B;
      OP_OR:    resultNext = A | B;
      OP_ADD: begin
        resultNext = sumVal;
        ovflNext   = (A[WIDTH-1] == B[WIDTH-1]) && (sumVal[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        resultNext = diffVal;
        ovflNext   = (A[WIDTH-1] != B[WIDTH-1]) && (diffVal[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:   resultNext = A ^ B;
      OP_NOR:   resultNext = ~(A | B);
      OP_NAND:  resultNext = ~(A & B);
      OP_INV:   resultNext = ~A;
`ifdef ALU16_SHIFT_OPS_EN
      OP_SLL:   resultNext = sllVal;
      OP_SRL:   resultNext = srlVal;
      OP_SRA:   resultNext = sraVal;
`endif
      OP_SLT:   resultNext = {{(WIDTH-1){1'b0}}, lessThan};
      OP_PASSB: resultNext = B;
      default:  resultNext = '0;   // reserved opcodes
    endcase
  end

  // Flags are taken from the same value loaded into R so they always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      R          <= '0;
      isZero     <= 1'b1;
      isNegative <= 1'b0;
      ovfl       <= 1'b0;
    end else if (en) begin
      R          <= resultNext;
      isZero     <= (resultNext == '0);
      isNegative <= resultNext[WIDTH-1];
      ovfl       <= ovflNext;
    end
  end

endmodule

// File: tb/tb_alu_16b.sv
// ---------------------------------------------------------------------------
// tb_alu_16b -- self-checking bench for alu_16b.
//   A behavioural reference (integer arithmetic) tracks what the output
//   registers must hold; a compare process checks the DUT against it on every
//   falling edge. Directed vectors additionally check hand-computed literals.
// ---------------------------------------------------------------------------
module tb_alu_16b;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  op;
  logic [15:0] R;
  logic        isZero;
  logic        isNegative;
  logic        ovfl;

  int total = 0;
  int bad   = 0;

  alu_16b #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .A          (A),
    .B          (B),
    .op         (op),
    .R          (R),
    .isZero     (isZero),
    .isNegative (isNegative),
    .ovfl       (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {R, isZero, isNegative, ovfl}
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] o);
    int          sa;
    int          sb;
    int          s;
    logic [15:0] r;
    logic        v;
    sa = $signed(a);
    sb = $signed(b);
    s  = 0;
    r  = 16'h0000;
    v  = 1'b0;
    case (o)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        s = sa + sb;
        r = s[15:0];
        v = (s > 32767) || (s < -32768);
      end
      4'd3: begin
        s = sa - sb;
        r = s[15:0];
        v = (s > 32767) || (s < -32768);
      end
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = ~(a & b);
      4'd7:  r = ~a;
`ifdef ALU16_SHIFT_OPS_EN
      4'd8:  r = a << b[3:0];
      4'd9:  r = a >> b[3:0];
      4'd10: begin
        s = sa >>> b[3:0];
        r = s[15:0];
      end
`endif
      4'd11: r = (sa < sb) ? 16'h0001 : 16'h0000;
      4'd12: r = b;
      default: r = 16'h0000;
    endcase
    return {r, (r == 16'h0000), r[15], v};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual R=%h z=%b n=%b v=%b required R=%h z=%b n=%b v=%b",
               name, act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Reference register state, updated on the same edge as the DUT.
  logic [18:0] expState;
  logic        modelValid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      expState   = {16'h0000, 1'b1, 1'b0, 1'b0};
      modelValid = 1'b1;
    end else if (en && modelValid) begin
      expState = model(A, B, op);
    end
  end

  always @(negedge clk) begin
    if (modelValid) check("model", {R, isZero, isNegative, ovfl}, expState);
  end

  // Apply one vector for one clock, then check the hand-computed literal.
  task automatic applyVec(input string name, input logic e, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] o,
                          input logic [15:0] expR, input logic expZ,
                          input logic expN, input logic expV);
    en = e;
    A  = a;
    B  = b;
    op = o;
    @(posedge clk);
    #1;
    $display("vec %-8s en=%b op=%0d A=%h B=%h -> R=%h z=%b n=%b v=%b",
             name, e, o, a, b, R, isZero, isNegative, ovfl);
    check(name, {R, isZero, isNegative, ovfl}, {expR, expZ, expN, expV});
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    A     = 16'h1234;
    B     = 16'h5678;
    op    = 4'd2;
    @(posedge clk);
    #1;
    check("reset", {R, isZero, isNegative, ovfl}, {16'h0000, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;

    // Hold: new inputs with en=0 must not disturb reset values.
    applyVec("hold0", 1'b0, 16'h8000, 16'h0001, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0);

    applyVec("AND",   1'b1, 16'hFFFF, 16'h0001, 4'd0,  16'h0001, 1'b0, 1'b0, 1'b0);
    applyVec("OR",    1'b1, 16'hFFFF, 16'h0001, 4'd1,  16'hFFFF, 1'b0, 1'b1, 1'b0);
    applyVec("XOR",   1'b1, 16'hFFFF, 16'h0001, 4'd4,  16'hFFFE, 1'b0, 1'b1, 1'b0);
    applyVec("NOR",   1'b1, 16'hFFFF, 16'h0001, 4'd5,  16'h0000, 1'b1, 1'b0, 1'b0);
    applyVec("NAND",  1'b1, 16'hFFFF, 16'h0001, 4'd6,  16'hFFFE, 1'b0, 1'b1, 1'b0);
    applyVec("INV",   1'b1, 16'hFFFF, 16'h0001, 4'd7,  16'h0000, 1'b1, 1'b0, 1'b0);
    applyVec("PASSB", 1'b1, 16'hFFFF, 16'h0001, 4'd12, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyVec("ADD",   1'b1, 16'hFFFF, 16'h0001, 4'd2,  16'h0000, 1'b1, 1'b0, 1'b0);
    applyVec("SUB",   1'b1, 16'hFFFF, 16'h0001, 4'd3,  16'hFFFE, 1'b0, 1'b1, 1'b0);
    applyVec("SUBovf",1'b1, 16'h8000, 16'h0001, 4'd3,  16'h7FFF, 1'b0, 1'b0, 1'b1);
    // Hold with overflow set: flags must stay as well.
    applyVec("hold1", 1'b0, 16'h0000, 16'h0000, 4'd0,  16'h7FFF, 1'b0, 1'b0, 1'b1);
    applyVec("ADDovf",1'b1, 16'h7FFF, 16'h0001, 4'd2,  16'h8000, 1'b0, 1'b1, 1'b1);
    applyVec("ADDneg",1'b1, 16'h8000, 16'h8000, 4'd2,  16'h0000, 1'b1, 1'b0, 1'b1);
    applyVec("SUBnov",1'b1, 16'h7FFF, 16'hFFFF, 4'd3,  16'h8000, 1'b0, 1'b1, 1'b1);
    applyVec("SLT1",  1'b1, 16'h8000, 16'h0001, 4'd11, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyVec("SLT0",  1'b1, 16'h0001, 16'h8000, 4'd11, 16'h0000, 1'b1, 1'b0, 1'b0);
    applyVec("SLTeq", 1'b1, 16'h1234, 16'h1234, 4'd11, 16'h0000, 1'b1, 1'b0, 1'b0);
    applyVec("SLTpos",1'b1, 16'h0003, 16'h0005, 4'd11, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyVec("RSV13", 1'b1, 16'hFFFF, 16'hFFFF, 4'd13, 16'h0000, 1'b1, 1'b0, 1'b0);
    applyVec("RSV15", 1'b1, 16'hFFFF, 16'h0001, 4'd15, 16'h0000, 1'b1, 1'b0, 1'b0);

`ifdef ALU16_SHIFT_OPS_EN
    applyVec("SLL",   1'b1, 16'h8001, 16'h0004, 4'd8,  16'h0010, 1'b0, 1'b0, 1'b0);
    applyVec("SRL",   1'b1, 16'h8001, 16'h0004, 4'd9,  16'h0800, 1'b0, 1'b0, 1'b0);
    applyVec("SRA",   1'b1, 16'h8001, 16'h0004, 4'd10, 16'hF800, 1'b0, 1'b1, 1'b0);
    applyVec("SRAhi", 1'b1, 16'h8001, 16'hFFF4, 4'd10, 16'hF800, 1'b0, 1'b1, 1'b0);
    applyVec("SLL15", 1'b1, 16'h0003, 16'h000F, 4'd8,  16'h8000, 1'b0, 1'b1, 1'b0);
`else
    applyVec("SLLrsv",1'b1, 16'h8001, 16'h0004, 4'd8,  16'h0000, 1'b1, 1'b0, 1'b0);
    applyVec("SRLrsv",1'b1, 16'h8001, 16'h0004, 4'd9,  16'h0000, 1'b1, 1'b0, 1'b0);
    applyVec("SRArsv",1'b1, 16'h8001, 16'h0004, 4'd10, 16'h0000, 1'b1, 1'b0, 1'b0);
`endif

    // Load a non-reset value, then show reset wins over en.
    applyVec("preRst",1'b1, 16'h0F0F, 16'hF0F0, 4'd1,  16'hFFFF, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    applyVec("rstPri",1'b1, 16'h7FFF, 16'h0001, 4'd2,  16'h0000, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    // Pseudo-random sweep checked by the model process only.
    for (int i = 0; i < 200; i++) begin
      en = ($urandom_range(0, 7) != 0);
      A  = 16'($urandom);
      B  = 16'($urandom);
      op = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_16b.md
Name: alu_16b

Overview:
16-bit ALU for the 16-bit processor datapath (execute stage).
- Takes two 16-bit operands and a 4-bit opcode.
- Produces a registered 16-bit result plus zero, negative and signed-overflow flags.
- Outputs are registered once on the clock, so downstream logic sees stable flags for branch decisions.

Parameters:
WIDTH, 16, operand/result width; only 16 is supported and verified.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all outputs
en  input  1  capture enable; when low, outputs hold their previous values
A  input  16  operand A
B  input  16  operand B
op  input  4  operation select
R  output  16  registered result
isZero  output  1  registered; 1 when R == 16'h0000
isNegative  output  1  registered; equals R[15]
ovfl  output  1  registered signed-overflow flag

Behaviour:
- Single-cycle registered operation:
  - On a rising clk with reset=0 and en=1, outputs load the combinational result of the current A, B and op.
  - Latency is 1 clock.
  - A, B and op are sampled only at the edge.
- Reset:
  - On a rising clk with reset=1: R=0, isZero=1, isNegative=0, ovfl=0.
  - reset has priority over en.
- Opcode map:
  - 0 AND: A & B
  - 1 OR: A | B
  - 2 ADD: A + B, modulo 2^16
  - 3 SUB: A - B, modulo 2^16
  - 4 XOR: A ^ B
  - 5 NOR: ~(A | B)
  - 6 NAND: ~(A & B)
  - 7 INV: ~A (B ignored)
  - 8 SLL, 9 SRL, 10 SRA: see Optional Feature
  - 11 SLT: R = 16'h0001 if signed A < signed B, else 0; correct across overflow (use the true sign of A-B)
  - 12 PASSB: R = B
  - 13-15 reserved: R = 0, all flags computed from R = 0
- Overflow:
  - ADD: ovfl=1 iff A[15]==B[15] and R[15]!=A[15].
  - SUB: ovfl=1 iff A[15]!=B[15] and R[15]!=A[15].
  - All other ops: ovfl=0.
  - No carry-out port; carry/borrow beyond bit 15 is discarded.
- Flags:
  - isZero and isNegative are derived from the 16-bit result of every op, including logic ops.
  - They are registered together with R and always consistent with the R presented.
- en=0: R and all flags hold; inputs are ignored.
- No internal state besides the output registers; there are no multi-cycle ops.

Optional Feature:
Macro ALU16_SHIFT_OPS_EN.
- Defined:
  - op 8: SLL, R = A << B[3:0].
  - op 9: SRL, R = A >> B[3:0] (logical, zero fill).
  - op 10: SRA, R = A >>> B[3:0] (sign fill from A[15]).
  - B[15:4] ignored; ovfl=0 for all three.
- Not defined:
  - ops 8-10 behave as reserved: R=0, isZero=1, isNegative=0, ovfl=0.
  - No shifter logic is synthesized.

Test Plan:
- Reset/hold:
  - Assert reset 1 cycle -> R=0000, isZero=1, isNegative=0, ovfl=0.
  - en=0 with new A/B/op -> outputs unchanged.
- Logic ops, A=FFFF, B=0001, one op per cycle, each checked one cycle later:
  - AND -> R=0001.
  - OR -> FFFF.
  - XOR -> FFFE, neg=1.
  - NOR -> 0000, zero=1.
  - NAND -> FFFE, neg=1.
  - INV -> 0000, zero=1.
  - PASSB -> 0001.
- Arithmetic without overflow, A=FFFF, B=0001:
  - ADD -> R=0000, ovfl=0, zero=1, neg=0.
  - SUB -> R=FFFE, ovfl=0, zero=0, neg=1.
- Overflow:
  - SUB, A=8000, B=0001 -> R=7FFF, ovfl=1, zero=0, neg=0.
  - ADD, A=7FFF, B=0001 -> R=8000, ovfl=1, zero=0, neg=1.
- SLT and reserved:
  - SLT, A=8000, B=0001 -> R=0001.
  - SLT, A=0001, B=8000 -> R=0000.
  - op=15 -> R=0000, zero=1, ovfl=0.
- Shifts, A=8001, B=0004:
  - With ALU16_SHIFT_OPS_EN: SLL -> 0010; SRL -> 0800; SRA -> F800.
  - Without the macro: each of ops 8-10 -> 0000, zero=1.
